// File: rtl/mux_arb_pkg.sv
// Shared constants and state type for the round-robin 4:1 select arbiter.
package mux_arb_pkg;

  localparam int unsigned SEL_W        = 2;
  localparam int unsigned N_REQ        = 1 << SEL_W;
  localparam int unsigned HOLD_MAX_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr, wrapping.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] w_cand;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = '0;
    // Index arithmetic wraps naturally at SEL_W bits, giving the 3->0 rotation.
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_cand = ptr + SEL_W'(k);
      if (!found && req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 4:1 single-bit select with bounded grant tenure.
// Optional MUX_ARB_LOCK_EN adds a lock input that suppresses tenure preemption.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
`ifdef MUX_ARB_LOCK_EN
  input  logic             lock,
`endif
  input  logic [N_REQ-1:0] I,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] S,
  output logic             Y,
  output logic             y_valid,
  output logic             busy
);

  state_t           r_state, w_nx_state;
  logic [SEL_W-1:0] r_ptr, w_nx_ptr;
  logic [CNT_W-1:0] r_hold_cnt, w_nx_cnt;
  logic [N_REQ-1:0] r_gnt, w_nx_gnt;
  logic [SEL_W-1:0] r_S, w_nx_S;
  logic             r_Y, w_nx_Y;
  logic             r_y_valid, w_nx_valid;

  logic             w_lock;
  logic             w_rearb;
  logic             w_at_limit;
  logic [SEL_W-1:0] w_pick_ptr;
  logic             w_found;
  logic [SEL_W-1:0] w_idx;

`ifdef MUX_ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_at_limit = (r_hold_cnt == CNT_W'(HOLD_MAX - 1));

  // In GRANT the picker already sees the advanced pointer, so a release or
  // preemption re-arbitrates on the same edge without an idle bubble.
  assign w_pick_ptr = (r_state == GRANT) ? (r_S + SEL_W'(1)) : r_ptr;

  rr_pick u_pick (
    .req   (req),
    .ptr   (w_pick_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  always_comb begin
    w_nx_state = r_state;
    w_nx_ptr   = r_ptr;
    w_nx_cnt   = r_hold_cnt;
    w_nx_gnt   = r_gnt;
    w_nx_S     = r_S;
    w_nx_Y     = r_Y;
    w_nx_valid = 1'b0;
    w_rearb    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nx_state = GRANT;
          w_nx_S     = w_idx;
          w_nx_gnt   = N_REQ'(1) << w_idx;
          w_nx_cnt   = '0;
        end
      end
      GRANT: begin
        if (!req[r_S]) begin
          w_rearb = 1'b1;
        end else begin
          w_nx_Y     = I[r_S];
          w_nx_valid = 1'b1;
          if (w_at_limit && !w_lock) begin
            w_rearb = 1'b1;
          end else if (!w_at_limit) begin
            w_nx_cnt = r_hold_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_nx_state = IDLE;
        w_nx_gnt   = '0;
      end
    endcase

    if (w_rearb) begin
      w_nx_ptr = w_pick_ptr;
      if (w_found) begin
        w_nx_state = GRANT;
        w_nx_S     = w_idx;
        w_nx_gnt   = N_REQ'(1) << w_idx;
        w_nx_cnt   = '0;
      end else begin
        w_nx_state = IDLE;
        w_nx_gnt   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_S        <= '0;
      r_Y        <= 1'b0;
      r_y_valid  <= 1'b0;
    end else begin
      r_state    <= w_nx_state;
      r_ptr      <= w_nx_ptr;
      r_hold_cnt <= w_nx_cnt;
      r_gnt      <= w_nx_gnt;
      r_S        <= w_nx_S;
      r_Y        <= w_nx_Y;
      r_y_valid  <= w_nx_valid;
    end
  end

  assign gnt     = r_gnt;
  assign S       = r_S;
  assign Y       = r_Y;
  assign y_valid = r_y_valid;
  assign busy    = (r_state == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter against a tenure-counting reference model.
module tb_mux_rr_arbiter;

  localparam int HM = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] I;
  logic       lock;
  logic [3:0] gnt;
  logic [1:0] S;
  logic       Y;
  logic       y_valid;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the datapath, how many data cycles it has been served.
  int m_owner;
  int m_ptr;
  int m_served;
  int m_S;
  bit m_Y;
  bit m_v;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.HOLD_MAX(HM), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
`ifdef MUX_ARB_LOCK_EN
    .lock    (lock),
`endif
    .I       (I),
    .gnt     (gnt),
    .S       (S),
    .Y       (Y),
    .y_valid (y_valid),
    .busy    (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (p + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic [3:0] d, input logic rs, input logic lk);
    int  o;
    bit  pass;
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_served = 0; m_S = 0; m_Y = 0; m_v = 0;
      return;
    end
    if (m_owner < 0) begin
      m_v     = 0;
      m_owner = pick(r, m_ptr);
      if (m_owner >= 0) begin
        m_S = m_owner; m_served = 0;
      end
    end else begin
      o    = m_owner;
      pass = 0;
      if (!r[o]) begin
        m_v  = 0;
        pass = 1;
      end else begin
        m_Y = d[o];
        m_v = 1;
        m_served++;
        if (m_served >= HM && !lk) pass = 1;
      end
      if (pass) begin
        m_ptr   = (o + 1) % 4;
        m_owner = pick(r, m_ptr);
        if (m_owner >= 0) begin
          m_S = m_owner; m_served = 0;
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic rs, input logic lk);
    logic [3:0] eg;
    req = r; I = d; rst = rs; lock = lk;
    @(posedge clk);
`ifdef MUX_ARB_LOCK_EN
    model_step(r, d, rs, lk);
`else
    model_step(r, d, rs, 1'b0);
`endif
    #1;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    check_eq("gnt",     32'(gnt),     32'(eg));
    check_eq("S",       32'(S),       32'(m_S));
    check_eq("Y",       32'(Y),       32'(m_Y));
    check_eq("y_valid", 32'(y_valid), 32'(m_v));
    check_eq("busy",    32'(busy),    32'(m_owner >= 0));
  endtask

  initial begin
    logic [3:0] r;
    logic       lk;

    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_S",   32'(S),   32'd0);

    // Reset in the middle of a grant
    for (int i = 0; i < 3; i++) step(4'b0010, 4'b1111, 1'b0, 1'b0);
    step(4'b0010, 4'b1111, 1'b1, 1'b0);
    check_eq("midrst_gnt",   32'(gnt),     32'd0);
    check_eq("midrst_valid", 32'(y_valid), 32'd0);
    step(4'b0010, 4'b0000, 1'b0, 1'b0);
    check_eq("regrant_gnt", 32'(gnt), 32'b0010);

    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);

    // Single requester with toggling data, then voluntary release
    for (int i = 0; i < 5; i++) step(4'b0100, (i % 2) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    check_eq("rel_S",    32'(S),    32'd2);
    check_eq("rel_busy", 32'(busy), 32'd0);

    // Preemption between two requesters, then full fairness rotation
    for (int i = 0; i < 40; i++) step(4'b0011, 4'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) step(4'b1111, 4'($urandom), 1'b0, 1'b0);

    // Release coinciding with tenure expiry counts as release
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    step(4'b1000, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(4'b1001, 4'b1111, 1'b0, 1'b0);
    step(4'b0001, 4'b1111, 1'b0, 1'b0);
    check_eq("relexp_valid", 32'(y_valid), 32'd0);
    check_eq("relexp_gnt",   32'(gnt),     32'b0001);

`ifdef MUX_ARB_LOCK_EN
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(4'b0011, 4'($urandom), 1'b0, 1'b1);
    check_eq("lock_hold", 32'(gnt), 32'b0001);
    step(4'b0010, 4'b0000, 1'b0, 1'b1);
    check_eq("lock_rel", 32'(gnt), 32'b0010);
`endif

    // Randomized traffic with sticky requests, occasional reset and lock flips
    r  = 4'b0000;
    lk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
      if ($urandom_range(15) == 0) lk = ~lk;
      step(r, 4'($urandom), ($urandom_range(99) == 0), lk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin controller that shares the 4:1 single-bit select datapath between four requesters.
- Owns the 2-bit select, grants one requester at a time, and limits each tenure to a maximum cycle count.
- Registers the selected data bit and qualifies it with a valid flag for downstream logic.
- Sits between the four bit-serial sources and the shared consumer.

Parameters:
SEL_W, 2, select width; N_REQ = 2**SEL_W = 4, fixed for this block.
HOLD_MAX, 8, maximum grant tenure in cycles (legal range 1..255).
CNT_W, 8, width of the tenure counter; must satisfy 2**CNT_W > HOLD_MAX.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
req  in  4  request per source; held high while the source wants the datapath.
I  in  4  data bit per source.
gnt  out  4  one-hot grant, registered.
S  out  2  select, registered; encodes the granted index.
Y  out  1  registered data: value of I[S] sampled on the previous edge.
y_valid  out  1  Y carries granted data.
busy  out  1  state == GRANT.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: gnt=0, S=0, Y=0, y_valid=0, busy=0, ptr=0, hold_cnt=0, state=IDLE. Reset mid-grant drops the grant on that edge; no data leaks out after the reset edge.
- States: IDLE, GRANT.
- Pick function: first set bit of req, searching from ptr upward with wrap 3->0.
- IDLE, req==0: stay in IDLE; y_valid=0.
- IDLE, req!=0: on that edge, winner w latches into S and gnt=1<<w; hold_cnt=0; state=GRANT.
  - Grant latency is 1 cycle from request.
- GRANT, each edge, checked in priority order:
  - a) req[S]==0 (voluntary release): Y holds, y_valid<=0, ptr<=S+1 mod 4, then re-arbitrate.
  - b) req[S]==1 and hold_cnt==HOLD_MAX-1 (preemption): Y<=I[S], y_valid<=1, ptr<=S+1 mod 4, then re-arbitrate.
  - c) otherwise: Y<=I[S], y_valid<=1, hold_cnt<=hold_cnt+1.
- Re-arbitrate: pick using the new ptr over the current req.
  - Any winner: grant it directly with no idle bubble; hold_cnt=0. A preempted requester is eligible only after the other three in rotation.
  - No winner: state=IDLE, gnt=0; S keeps its last value.
- Release and expiry on the same edge: treated as release (a).
- Data latency: Y/y_valid lag the sampled I[S] by 1 cycle.
- gnt is always one-hot or zero. S changes only on a grant edge.

Optional Feature:
- Macro MUX_ARB_LOCK_EN.
- Defined: adds input port lock (1 bit, after req). While lock==1 in GRANT, rule (b) is suppressed; hold_cnt saturates at HOLD_MAX-1. Rule (a) still applies.
- Undefined: no lock port; preemption is always active.

Decomposition:
- Package mux_arb_pkg: SEL_W, N_REQ, state enum {IDLE, GRANT}, default HOLD_MAX.
- Sub-module rr_pick: combinational. Inputs req[3:0] and ptr[1:0]; outputs found and idx[1:0]. Instantiated once.

Test Plan:
- Reset mid-grant: req=4'b0010 until granted, assert rst for 1 cycle -> next edge gnt=0, S=0, y_valid=0, state IDLE. Keep req=4'b0010 after rst drops -> gnt=4'b0010 one cycle later.
- Single requester: req=4'b0100, I[2] toggling -> gnt=4'b0100, S=2 after 1 cycle. Y follows I[2] delayed 1 cycle, y_valid=1.
- Voluntary release: req[2] drops after 3 valid cycles -> y_valid=0 next edge, gnt=0, S stays 2, busy=0.
- Preemption with HOLD_MAX=8: req=4'b0011 held -> source 0 gets 8 valid cycles. Grant passes to source 1 with no bubble (y_valid stays 1), then back to 0 after 8 more cycles.
- Fairness: req=4'b1111 held 64 cycles -> grant order 0,1,2,3,0,... with exactly 8 cycles each.
- Simultaneous release and expiry on cycle 8, req=4'b1001, granted=3 -> treated as release: y_valid=0 that edge, next grant to 0. With MUX_ARB_LOCK_EN and lock=1, req=4'b0011: source 0 holds beyond 8 cycles until req[0] drops.
